jt053247_draw: RTL and testbench

Sprite line drawer sitting directly downstream of the k053246/7 table scanner. It accepts one 16-pixel tile row per `dr_start` pulse, fetches the row from graphics ROM as two 32-bit words, and applies horizontal zoom and flip. It then writes the non-transparent pixels into the external object line buffer. `dr_busy` throttles the scanner.

---
 rtl/jt053247_pkg.sv | 13 +
 rtl/jt053247_draw.sv | 149 ++++++++++++++
 tb/tb_jt053247_draw.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jt053247_pkg.sv
// jt053247_pkg: shared types, constants and pixel picker for the sprite line drawer
package jt053247_pkg;
   typedef enum logic [1:0] {IDLE, FETCH0, FETCH1, DRAW} state_t;
   localparam logic [11:0] ZOOM_UNITY = 12'h40;
   localparam logic [15:0] TILE_SPAN  = 16'h400;
   localparam int          ROM_AW     = 21;
   // Pixel n sits in the top nibble after shifting left by 4n; 15-src is ~src on four bits
   function automatic logic [3:0] pix_sel(input logic [63:0] row, input logic [15:0] acc, input logic flip);
      logic [63:0] s;
      s = row << {acc[9:6] ^ {4{flip}}, 2'b00};
      return s[63:60];
   endfunction
endpackage

// File: rtl/jt053247_draw.sv
// jt053247_draw: fetches one 16-pixel tile row and draws it zoomed/flipped into the object line buffer
module jt053247_draw
   import jt053247_pkg::*;
#(
   parameter int PW = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dr_start,
   output logic              dr_busy,
   input  logic [15:0]       code,
   input  logic [9:0]        attr,
   input  logic              hflip,
   input  logic              vflip,
   input  logic [8:0]        hpos,
   input  logic [3:0]        ysub,
   input  logic [11:0]       hzoom,
   input  logic              hz_keep,
   output logic [ROM_AW-1:0] rom_addr,
   output logic              rom_cs,
   input  logic              rom_ok,
   input  logic [31:0]       rom_data,
   output logic [8:0]        buf_addr,
   output logic [PW-1:0]     buf_din,
   output logic              buf_we
);
   state_t            state_q, state_d;
   logic              first_q, first_d, busy_q, busy_d, rom_cs_q, rom_cs_d, buf_we_q, buf_we_d;
   logic [15:0]       acc_q, acc_d, resid_q, resid_d, acc0, nxt;
   logic [63:0]       row_q, row_d;
   logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
   logic [8:0]        buf_addr_q, buf_addr_d, hpos_q;
   logic [PW-1:0]     buf_din_q, buf_din_d;
   logic [9:0]        attr_q;
   logic [11:0]       step_q;
   logic              hflip_q, take, ok;
   logic [3:0]        px;
   assign dr_busy  = busy_q;
   assign rom_cs   = rom_cs_q;
   assign rom_addr = rom_addr_q;
   assign buf_we   = buf_we_q;
   assign buf_addr = buf_addr_q;
   assign buf_din  = buf_din_q;
   // Next-state: buf_* are loaded with the pixel belonging to the accumulator that is current in the next cycle
   always_comb begin
      state_d    = state_q;
      first_d    = 1'b0;
      busy_d     = 1'b0;
      acc_d      = acc_q;
      resid_d    = resid_q;
      row_d      = row_q;
      rom_cs_d   = 1'b0;
      rom_addr_d = rom_addr_q;
      buf_we_d   = 1'b0;
      buf_addr_d = buf_addr_q;
      buf_din_d  = buf_din_q;
      take       = state_q == IDLE && dr_start && !busy_q;
      acc0       = hz_keep ? resid_q : 16'd0;
      nxt        = acc_q + {4'd0, step_q};
      ok         = rom_ok && !first_q;
      px         = pix_sel(row_q, nxt, hflip_q);
      case (state_q)
         IDLE: if (take) begin
            busy_d = 1'b1;
            if (acc0 >= TILE_SPAN) resid_d = acc0 - TILE_SPAN;
            else begin
               state_d    = FETCH0;
               first_d    = 1'b1;
               acc_d      = acc0;
               rom_cs_d   = 1'b1;
               rom_addr_d = {code, ysub ^ {4{vflip}}, 1'b0};
            end
         end
         FETCH0: begin
            busy_d   = 1'b1;
            rom_cs_d = 1'b1;
            if (ok) begin
               row_d[63:32]  = rom_data;
               state_d       = FETCH1;
               first_d       = 1'b1;
               rom_addr_d[0] = 1'b1;
            end
         end
         FETCH1: begin
            busy_d   = 1'b1;
            rom_cs_d = !ok;
            if (ok) begin
               row_d[31:0] = rom_data;
               px          = pix_sel(row_d, acc_q, hflip_q);
               state_d     = DRAW;
               buf_we_d    = px != 4'd0;
               buf_addr_d  = hpos_q;
               buf_din_d   = PW'({attr_q, px});
            end
         end
         DRAW: begin
            if (nxt >= TILE_SPAN) begin
               state_d = IDLE;
               resid_d = nxt - TILE_SPAN;
            end else begin
               busy_d     = 1'b1;
               acc_d      = nxt;
               buf_we_d   = px != 4'd0;
               buf_addr_d = buf_addr_q + 9'd1;
               buf_din_d  = PW'({attr_q, px});
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // State and output registers; request parameters are captured when a start is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         first_q    <= 1'b0;
         busy_q     <= 1'b0;
         acc_q      <= '0;
         resid_q    <= '0;
         row_q      <= '0;
         rom_cs_q   <= 1'b0;
         rom_addr_q <= '0;
         buf_we_q   <= 1'b0;
         buf_addr_q <= '0;
         buf_din_q  <= '0;
         attr_q     <= '0;
         hflip_q    <= 1'b0;
         hpos_q     <= '0;
         step_q     <= ZOOM_UNITY;
      end else begin
         state_q    <= state_d;
         first_q    <= first_d;
         busy_q     <= busy_d;
         acc_q      <= acc_d;
         resid_q    <= resid_d;
         row_q      <= row_d;
         rom_cs_q   <= rom_cs_d;
         rom_addr_q <= rom_addr_d;
         buf_we_q   <= buf_we_d;
         buf_addr_q <= buf_addr_d;
         buf_din_q  <= buf_din_d;
         if (take) begin
            attr_q  <= attr;
            hflip_q <= hflip;
            hpos_q  <= hpos;
            step_q  <= hzoom == 12'd0 ? 12'd1 : hzoom;
         end
      end
   end
endmodule

// File: tb/tb_jt053247_draw.sv
// tb_jt053247_draw: directed and randomized checks of the sprite line drawer against a pixel-list model
module tb_jt053247_draw;
   logic clk = 1'b0;
   logic rst = 1'b1, dr_start = 1'b0, hflip = 1'b0, vflip = 1'b0, hz_keep = 1'b0;
   logic dr_busy, rom_cs, rom_ok, buf_we;
   logic [15:0] code = '0;
   logic [9:0]  attr = '0;
   logic [8:0]  hpos = '0, buf_addr;
   logic [3:0]  ysub = '0;
   logic [11:0] hzoom = '0;
   logic [20:0] rom_addr, last_addr = '0;
   logic [31:0] rom_data;
   logic [13:0] buf_din;
   int total = 0, bad = 0, cyc = 0, lat = 0, wcnt = 0;
   logic fixed = 1'b1;
   typedef struct {logic [8:0] a; logic [13:0] d;} wr_t;
   wr_t expq[$];
   logic [20:0] alog[$];
   int wr_seen = 0, first_wc = 0, bcyc = 0, nw_exp = 0, ndraw = 0, t0 = 0;
   logic got_first = 1'b0, saw_zero = 1'b0, prev_cs = 1'b0;
   logic [8:0] fa = '0, la = '0;
   logic [13:0] fd = '0;
   logic [15:0] mres = '0;

   jt053247_draw #(.PW(14)) dut (
      .clk(clk), .rst(rst), .dr_start(dr_start), .dr_busy(dr_busy),
      .code(code), .attr(attr), .hflip(hflip), .vflip(vflip), .hpos(hpos),
      .ysub(ysub), .hzoom(hzoom), .hz_keep(hz_keep),
      .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
      .buf_addr(buf_addr), .buf_din(buf_din), .buf_we(buf_we)
   );

   function automatic logic [31:0] word(input logic [20:0] a, input logic f);
      if (f) return a[0] ? 32'h89ABCDEF : 32'h12345670;
      return ({a, 11'h5A3} * 32'h9E3779B1) ^ 32'h3C5AF00F;
   endfunction

   always #5 clk = ~clk;

   // ROM: data follows the address, valid once the address has been held for lat cycles
   always @(posedge clk) begin
      cyc       <= cyc + 1;
      last_addr <= rom_addr;
      wcnt      <= (rom_cs && rom_addr == last_addr) ? wcnt + 1 : 0;
   end
   assign rom_ok   = (lat == 0) || (wcnt >= lat);
   assign rom_data = word(rom_addr, fixed);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Compare process: every write is matched against the model's expected list in order
   always @(negedge clk) begin
      if (!rst) begin
         if (rom_cs && (!prev_cs || rom_addr != alog[$])) alog.push_back(rom_addr);
         prev_cs = rom_cs;
         if (buf_we) begin
            if (!got_first) begin
               got_first = 1'b1;
               fa = buf_addr;
               fd = buf_din;
               first_wc = cyc;
            end
            la = buf_addr;
            wr_seen++;
            if (buf_addr == 9'd0) saw_zero = 1'b1;
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_write: got addr %0h data %0h want none", buf_addr, buf_din);
            end else begin
               wr_t e;
               e = expq.pop_front();
               chk("wr_addr", buf_addr, e.a);
               chk("wr_data", buf_din, e.d);
            end
         end
         if (!dr_busy) begin
            chk("idle_we", buf_we, 0);
            chk("idle_cs", rom_cs, 0);
         end
      end
   end

   task automatic model(input logic [15:0] c, input logic [9:0] at, input logic hf, input logic vf,
                        input logic [8:0] hp, input logic [3:0] ys, input logic [11:0] hz, input logic keep);
      logic [15:0] acc, step;
      logic [63:0] r64;
      logic [3:0] rw, src, idx, px;
      int k;
      step = (hz == 12'd0) ? 16'd1 : {4'd0, hz};
      acc = keep ? mres : 16'd0;
      nw_exp = 0;
      ndraw = 0;
      if (acc >= 16'h400) mres = acc - 16'h400;
      else begin
         rw = ys ^ {4{vf}};
         r64 = {word({c, rw, 1'b0}, fixed), word({c, rw, 1'b1}, fixed)};
         k = 0;
         while (acc < 16'h400) begin
            src = acc[9:6];
            idx = hf ? 4'd15 - src : src;
            px = r64[63 - 4 * int'(idx) -: 4];
            if (px != 4'd0) begin
               expq.push_back('{9'(hp + 9'(k)), {at, px}});
               nw_exp++;
            end
            k++;
            acc = acc + step;
         end
         ndraw = k;
         mres = acc - 16'h400;
      end
   endtask

   task automatic req(input logic [15:0] c, input logic [9:0] at, input logic hf, input logic vf,
                      input logic [8:0] hp, input logic [3:0] ys, input logic [11:0] hz, input logic keep,
                      input logic spur);
      model(c, at, hf, vf, hp, ys, hz, keep);
      @(negedge clk);
      code = c; attr = at; hflip = hf; vflip = vf; hpos = hp; ysub = ys; hzoom = hz; hz_keep = keep;
      dr_start = 1'b1;
      got_first = 1'b0; wr_seen = 0; saw_zero = 1'b0; first_wc = 0;
      alog.delete();
      @(negedge clk);
      t0 = cyc;
      dr_start = spur;
      if (spur) begin
         code = 16'($urandom);
         hzoom = 12'($urandom);
         ysub = 4'($urandom);
      end
      bcyc = 0;
      while (dr_busy && bcyc < 3000) begin
         bcyc++;
         @(negedge clk);
         dr_start = 1'b0;
      end
      if (bcyc >= 3000) chk("busy_timeout", dr_busy, 0);
      chk("drained", expq.size(), 0);
      chk("writes", wr_seen, nw_exp);
      if (lat == 0) chk("busy_len", bcyc, ndraw == 0 ? 1 : 4 + ndraw);
      expq.delete();
   endtask

   initial begin
      int n;
      int sel;
      logic [11:0] hz;
      repeat (3) @(negedge clk);
      chk("rst_busy", dr_busy, 0);
      chk("rst_cs", rom_cs, 0);
      chk("rst_raddr", rom_addr, 0);
      chk("rst_we", buf_we, 0);
      chk("rst_baddr", buf_addr, 0);
      chk("rst_din", buf_din, 0);
      rst = 1'b0;
      // 1:1 zoom, zero-latency ROM
      req(16'h1234, 10'h2A5, 1'b0, 1'b0, 9'h100, 4'd3, 12'h40, 1'b0, 1'b0);
      chk("t1_addr0", alog[0], {16'h1234, 4'd3, 1'b0});
      chk("t1_addr1", alog[1], {16'h1234, 4'd3, 1'b1});
      chk("t1_writes", wr_seen, 15);
      chk("t1_first_addr", fa, 9'h100);
      chk("t1_first_data", fd, {10'h2A5, 4'h1});
      chk("t1_first_time", first_wc - t0, 4);
      chk("t1_busy", bcyc, 20);
      chk("t1_last", la, 9'h10F);
      // both flips
      req(16'h1234, 10'h155, 1'b1, 1'b1, 9'h100, 4'd3, 12'h40, 1'b0, 1'b0);
      chk("t2_addr0", alog[0], {16'h1234, 4'hC, 1'b0});
      chk("t2_first_addr", fa, 9'h100);
      chk("t2_first_data", fd, {10'h155, 4'hF});
      chk("t2_last_data_addr", la, 9'h10F);
      // 2x enlarge
      req(16'h1234, 10'h001, 1'b0, 1'b0, 9'h100, 4'd3, 12'h20, 1'b0, 1'b0);
      chk("t3_draw", ndraw, 32);
      chk("t3_writes", wr_seen, 30);
      chk("t3_busy", bcyc, 36);
      chk("t3_last", la, 9'h11F);
      // half size, two tiles
      req(16'h1234, 10'h002, 1'b0, 1'b0, 9'h080, 4'd3, 12'h80, 1'b0, 1'b0);
      chk("t4_busy", bcyc, 12);
      chk("t4_writes", wr_seen, 8);
      chk("t4_resid", mres, 16'h0);
      req(16'h1234, 10'h002, 1'b0, 1'b0, 9'h088, 4'd3, 12'h80, 1'b1, 1'b0);
      chk("t4b_busy", bcyc, 12);
      chk("t4b_first", fd, {10'h002, 4'h1});
      // 0x60 step carries a residue into the next tile
      req(16'h1234, 10'h003, 1'b0, 1'b0, 9'h040, 4'd3, 12'h60, 1'b0, 1'b0);
      chk("t5_draw", ndraw, 11);
      chk("t5_busy", bcyc, 15);
      chk("t5_resid", mres, 16'h20);
      req(16'h1234, 10'h003, 1'b0, 1'b0, 9'h04B, 4'd3, 12'h60, 1'b1, 1'b0);
      chk("t5b_first", fd, {10'h003, 4'h1});
      chk("t5b_first_addr", fa, 9'h04B);
      // huge step leaves a residue that skips whole tiles; starts during busy are ignored
      req(16'h1234, 10'h004, 1'b0, 1'b0, 9'h010, 4'd3, 12'hFFF, 1'b0, 1'b0);
      chk("t6_draw", ndraw, 1);
      chk("t6_resid", mres, 16'hBFF);
      req(16'h1234, 10'h004, 1'b0, 1'b0, 9'h011, 4'd3, 12'h40, 1'b1, 1'b1);
      chk("t6_skip_busy", bcyc, 1);
      chk("t6_skip_writes", wr_seen, 0);
      chk("t6_skip_resid", mres, 16'h7FF);
      req(16'h1234, 10'h004, 1'b0, 1'b0, 9'h012, 4'd3, 12'h40, 1'b1, 1'b0);
      req(16'h1234, 10'h004, 1'b0, 1'b0, 9'h013, 4'd3, 12'h40, 1'b1, 1'b0);
      chk("t6_tail_draw", ndraw, 1);
      chk("t6_tail_data", fd, {10'h004, 4'hF});
      // slow ROM, reset in the middle of drawing
      lat = 3;
      model(16'h1234, 10'h005, 1'b0, 1'b0, 9'h100, 4'd3, 12'h40, 1'b0);
      @(negedge clk);
      code = 16'h1234; attr = 10'h005; hflip = 1'b0; vflip = 1'b0; hpos = 9'h100;
      ysub = 4'd3; hzoom = 12'h40; hz_keep = 1'b0; dr_start = 1'b1;
      @(negedge clk);
      dr_start = 1'b0;
      n = 0;
      while (!buf_we && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("r_reach_draw", buf_we, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("r_we", buf_we, 0);
      chk("r_busy", dr_busy, 0);
      chk("r_cs", rom_cs, 0);
      rst = 1'b0;
      expq.delete();
      mres = '0;
      @(negedge clk);
      chk("r_post_we", buf_we, 0);
      req(16'h0042, 10'h006, 1'b0, 1'b0, 9'h1FA, 4'd3, 12'h40, 1'b0, 1'b0);
      chk("r_first_addr", fa, 9'h1FA);
      chk("r_wrap_zero", saw_zero, 1);
      // randomized tiles
      fixed = 1'b0;
      for (int i = 0; i < 30; i++) begin
         lat = $urandom_range(0, 3);
         sel = $urandom_range(0, 14);
         hz = sel == 0 ? 12'd0 : sel < 3 ? 12'($urandom_range(12'h400, 12'hFFF)) : 12'($urandom_range(8, 12'h200));
         req(16'($urandom), 10'($urandom), 1'($urandom), 1'($urandom), 9'($urandom), 4'($urandom),
             hz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
